// File: rtl/tc_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tc_mul_pipe
// Brief    : Pipelined signed multiplier: A*B, optional negate, arithmetic
//            right shift, narrow to DOUT_WIDTH with range flag. Define
//            TC_MUL_SAT_EN to clamp instead of wrap when narrowing.
// Revision : 1.0 - initial release
// ============================================================================
module tc_mul_pipe #(
  parameter int DIN0_WIDTH = 17,
  parameter int DIN1_WIDTH = 18,
  parameter int DOUT_WIDTH = 31,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ce,
  input  logic                         din_vld,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         neg,
  output logic                         dout_vld,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int PW           = DIN0_WIDTH + DIN1_WIDTH;
  localparam int QW           = PW + 1;
  localparam bit OVF_POSSIBLE = (DOUT_WIDTH < QW - SHIFT);

  logic [NUM_STAGE-1:0] vld_q, vld_d;

  generate
    if (NUM_STAGE == 1) begin : g_vld_one
      always_comb vld_d = ce ? din_vld : vld_q;
    end else begin : g_vld_multi
      always_comb vld_d = ce ? {vld_q[NUM_STAGE-2:0], din_vld} : vld_q;
    end
  endgenerate

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  logic signed [DIN0_WIDTH-1:0] a_q, a_d;
  logic signed [DIN1_WIDTH-1:0] b_q, b_d;
  logic                         neg_q, neg_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    neg_d = neg_q;
    if (ce) begin
      a_d   = din0;
      b_d   = din1;
      neg_d = neg;
    end
  end

  // Operands are cleared too so a single-stage build reads dout = 0 in reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      neg_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      neg_q <= neg_d;
    end
  end

  logic signed [PW-1:0] prod;
  logic signed [QW-1:0] prod_x;
  logic signed [QW-1:0] q_calc;
  logic signed [QW-1:0] q_fin;

  // One extra bit so negating (-2^(A-1))*(-2^(B-1)) stays exact.
  assign prod   = PW'(a_q) * PW'(b_q);
  assign prod_x = {prod[PW-1], prod};
  assign q_calc = neg_q ? -prod_x : prod_x;

  generate
    if (NUM_STAGE >= 3) begin : g_qpipe
      logic signed [QW-1:0] q_pipe_q [NUM_STAGE-2];

      // Stage i+2 only loads when it receives valid data; bubbles leave it idle.
      always_ff @(posedge ap_clk) begin
        if (ce && vld_q[0]) begin
          q_pipe_q[0] <= q_calc;
        end
        for (int i = 1; i < NUM_STAGE - 2; i++) begin
          if (ce && vld_q[i]) begin
            q_pipe_q[i] <= q_pipe_q[i-1];
          end
        end
      end

      assign q_fin = q_pipe_q[NUM_STAGE-3];
    end else begin : g_qdirect
      assign q_fin = q_calc;
    end
  endgenerate

  logic signed [QW-1:0]         r;
  logic [QW-DOUT_WIDTH:0]       r_hi;
  logic                         oor;
  logic signed [DOUT_WIDTH-1:0] narrow;

  // In range exactly when every bit above the DOUT sign bit matches it.
  assign r    = q_fin >>> SHIFT;
  assign r_hi = r[QW-1:DOUT_WIDTH-1];
  assign oor  = OVF_POSSIBLE && !((&r_hi) || !(|r_hi));

`ifdef TC_MUL_SAT_EN
  localparam logic signed [DOUT_WIDTH-1:0] SAT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] SAT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  assign narrow = !oor ? r[DOUT_WIDTH-1:0] : (r[QW-1] ? SAT_MIN : SAT_MAX);
`else
  assign narrow = r[DOUT_WIDTH-1:0];
`endif

  generate
    if (NUM_STAGE == 1) begin : g_out_comb
      assign dout = narrow;
      assign ovf  = oor;
    end else begin : g_out_reg
      logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
      logic                         ovf_q, ovf_d;

      always_comb begin
        dout_d = dout_q;
        ovf_d  = ovf_q;
        if (ce) begin
          dout_d = narrow;
          ovf_d  = oor;
        end
      end

      always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
          dout_q <= '0;
          ovf_q  <= 1'b0;
        end else begin
          dout_q <= dout_d;
          ovf_q  <= ovf_d;
        end
      end

      assign dout = dout_q;
      assign ovf  = ovf_q;
    end
  endgenerate

  assign dout_vld = vld_q[NUM_STAGE-1];

endmodule
`default_nettype wire

// File: tb/tb_tc_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_mul_pipe
// Brief    : Scoreboard bench for tc_mul_pipe over three parameter sets that
//            share one input stream (default, 36-bit output, shift-by-4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_mul_pipe;

  typedef struct {
    longint val;
    bit     ovf;
    longint due;
  } exp_t;

`ifdef TC_MUL_SAT_EN
  localparam longint POS_OVF_DOUT = (longint'(1) <<< 30) - 1;
  localparam longint NEG_OVF_DOUT = -(longint'(1) <<< 30);
`else
  localparam longint POS_OVF_DOUT = 0;
  localparam longint NEG_OVF_DOUT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, ce, vld, neg;
  logic signed [16:0] a;
  logic signed [17:0] b;

  logic               d0_vld, d0_ovf, d1_vld, d1_ovf, d2_vld, d2_ovf;
  logic signed [30:0] d0_dout;
  logic signed [35:0] d1_dout;
  logic signed [30:0] d2_dout;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint en_cnt = 0;
  exp_t   q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  tc_mul_pipe u_def (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .din_vld(vld), .din0(a), .din1(b),
    .neg(neg), .dout_vld(d0_vld), .dout(d0_dout), .ovf(d0_ovf)
  );

  tc_mul_pipe #(.DOUT_WIDTH(36), .NUM_STAGE(3)) u_wide (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .din_vld(vld), .din0(a), .din1(b),
    .neg(neg), .dout_vld(d1_vld), .dout(d1_dout), .ovf(d1_ovf)
  );

  tc_mul_pipe #(.SHIFT(4), .NUM_STAGE(1)) u_shf (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .din_vld(vld), .din0(a), .din1(b),
    .neg(neg), .dout_vld(d2_vld), .dout(d2_dout), .ovf(d2_ovf)
  );

  // Reference arithmetic in 64-bit integers, independent of any pipeline detail.
  function automatic exp_t model(input longint av, input longint bv, input bit nv,
                                 input int dw, input int sh);
    exp_t   e;
    longint p, r, hi, lo;
    p  = av * bv;
    if (nv) p = -p;
    r  = p >>> sh;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -hi - 1;
    e.ovf = (r > hi) || (r < lo);
`ifdef TC_MUL_SAT_EN
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
`endif
    e.val = (r <<< (64 - dw)) >>> (64 - dw);
    e.due = 0;
    return e;
  endfunction

  function automatic longint rnd_a();
    logic signed [16:0] t;
    t = 17'($urandom);
    return t;
  endfunction

  function automatic longint rnd_b();
    logic signed [17:0] t;
    t = 18'($urandom);
    return t;
  endfunction

  task automatic drive(input bit c, input bit v, input longint av, input longint bv, input bit nv);
    exp_t e;
    ce  = c;
    vld = v;
    a   = av[16:0];
    b   = bv[17:0];
    neg = nv;
    if (c && v) begin
      e = model(av, bv, nv, 31, 0); e.due = en_cnt + 2; q0.push_back(e);
      e = model(av, bv, nv, 36, 0); e.due = en_cnt + 3; q1.push_back(e);
      e = model(av, bv, nv, 31, 4); e.due = en_cnt + 1; q2.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (ce) en_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, -5, 9, 1'b0);
    tick();
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    tick();
    n_chk += 3;
    if (d0_vld !== 1'b0 || d1_vld !== 1'b0 || d2_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_vld: got %0b%0b%0b required 000", d0_vld, d1_vld, d2_vld);
    end
    if (d0_dout !== 31'sd0 || d1_dout !== 36'sd0 || d2_dout !== 31'sd0) begin
      n_fail++; $display("FAIL reset_dout: got %0d/%0d/%0d required 0/0/0", d0_dout, d1_dout, d2_dout);
    end
    if (d0_ovf !== 1'b0 || d1_ovf !== 1'b0 || d2_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf: got %0b%0b%0b required 000", d0_ovf, d1_ovf, d2_ovf);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_t e;
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 22; i++) begin
      n_chk += 3;
      if (d0_vld) begin
        if (q0.size() == 0) begin
          n_fail++; $display("FAIL basic_d0_extra: dout_vld=1 required 0 at edge %0d", en_cnt);
        end else begin
          e = q0.pop_front();
          if (e.due != en_cnt || longint'(d0_dout) !== e.val || d0_ovf !== e.ovf) begin
            n_fail++; $display("FAIL basic_d0_out: got dout=%0d ovf=%0b edge %0d required dout=%0d ovf=%0b edge %0d",
                               d0_dout, d0_ovf, en_cnt, e.val, e.ovf, e.due);
          end
        end
      end else if (q0.size() != 0 && q0[0].due <= en_cnt) begin
        n_fail++; $display("FAIL basic_d0_missing: dout_vld=0 required 1 at edge %0d", q0[0].due);
      end
      if (d1_vld) begin
        if (q1.size() == 0) begin
          n_fail++; $display("FAIL basic_d1_extra: dout_vld=1 required 0 at edge %0d", en_cnt);
        end else begin
          e = q1.pop_front();
          if (e.due != en_cnt || longint'(d1_dout) !== e.val || d1_ovf !== e.ovf) begin
            n_fail++; $display("FAIL basic_d1_out: got dout=%0d ovf=%0b edge %0d required dout=%0d ovf=%0b edge %0d",
                               d1_dout, d1_ovf, en_cnt, e.val, e.ovf, e.due);
          end
        end
      end else if (q1.size() != 0 && q1[0].due <= en_cnt) begin
        n_fail++; $display("FAIL basic_d1_missing: dout_vld=0 required 1 at edge %0d", q1[0].due);
      end
      if (d2_vld) begin
        if (q2.size() == 0) begin
          n_fail++; $display("FAIL basic_d2_extra: dout_vld=1 required 0 at edge %0d", en_cnt);
        end else begin
          e = q2.pop_front();
          if (e.due != en_cnt || longint'(d2_dout) !== e.val || d2_ovf !== e.ovf) begin
            n_fail++; $display("FAIL basic_d2_out: got dout=%0d ovf=%0b edge %0d required dout=%0d ovf=%0b edge %0d",
                               d2_dout, d2_ovf, en_cnt, e.val, e.ovf, e.due);
          end
        end
      end else if (q2.size() != 0 && q2[0].due <= en_cnt) begin
        n_fail++; $display("FAIL basic_d2_missing: dout_vld=0 required 1 at edge %0d", q2[0].due);
      end
      case (i)
        0:       drive(1'b1, 1'b1, -3, 5, 1'b0);
        4:       drive(1'b1, 1'b1, -65536, -131072, 1'b1);
        5:       drive(1'b1, 1'b1, 65535, 131071, 1'b0);
        6:       drive(1'b1, 1'b1, -65536, 131071, 1'b1);
        7:       drive(1'b1, 1'b1, 0, -7, 1'b1);
        default: begin
          if (i >= 8 && i < 16) drive(1'b1, 1'b1, rnd_a(), rnd_b(), 1'($urandom_range(0, 1)));
          else drive(1'b1, 1'b0, 0, 0, 1'b0);
        end
      endcase
      tick();
    end
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      n_fail++; $display("FAIL basic_drain: pending %0d/%0d/%0d required 0/0/0", q0.size(), q1.size(), q2.size());
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b1, -65536, -131072, 1'b0);
    tick();
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    tick();
    n_chk++;
    if (d0_vld !== 1'b1 || longint'(d0_dout) !== POS_OVF_DOUT || d0_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_default: got vld=%0b dout=%0d ovf=%0b required vld=1 dout=%0d ovf=1",
                         d0_vld, d0_dout, d0_ovf, POS_OVF_DOUT);
    end
    tick();
    n_chk++;
    if (d1_vld !== 1'b1 || d1_dout !== 36'sh2_0000_0000 || d1_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_wide: got vld=%0b dout=%0d ovf=%0b required vld=1 dout=8589934592 ovf=0",
                         d1_vld, d1_dout, d1_ovf);
    end
    tick(); tick();
  endtask

  task automatic test_corner_negate();
    drive(1'b1, 1'b1, -65536, -131072, 1'b1);
    tick();
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    tick();
    n_chk++;
    if (d0_vld !== 1'b1 || longint'(d0_dout) !== NEG_OVF_DOUT || d0_ovf !== 1'b1) begin
      n_fail++; $display("FAIL neg_default: got vld=%0b dout=%0d ovf=%0b required vld=1 dout=%0d ovf=1",
                         d0_vld, d0_dout, d0_ovf, NEG_OVF_DOUT);
    end
    tick();
    n_chk += 2;
    if (d1_vld !== 1'b1 || d1_dout !== -36'sh2_0000_0000 || d1_ovf !== 1'b0) begin
      n_fail++; $display("FAIL neg_wide: got vld=%0b dout=%0d ovf=%0b required vld=1 dout=-8589934592 ovf=0",
                         d1_vld, d1_dout, d1_ovf);
    end
    if (d0_vld !== 1'b0) begin
      n_fail++; $display("FAIL neg_pulse_width: dout_vld=%0b required 0", d0_vld);
    end
    tick(); tick();
  endtask

  task automatic test_shift_floor();
    longint sa [5] = '{-1, 1, -17, 100, 1};
    longint sb [5] = '{7, 15, 1, 3, 15};
    bit     sn [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    longint se [5] = '{-1, 0, -2, 18, -1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, sa[i], sb[i], sn[i]);
      tick();
      n_chk++;
      if (d2_vld !== 1'b1 || longint'(d2_dout) !== se[i] || d2_ovf !== 1'b0) begin
        n_fail++; $display("FAIL shift_floor[%0d]: got vld=%0b dout=%0d ovf=%0b required vld=1 dout=%0d ovf=0",
                           i, d2_vld, d2_dout, d2_ovf, se[i]);
      end
    end
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    tick();
    n_chk++;
    if (d2_vld !== 1'b0) begin
      n_fail++; $display("FAIL shift_bubble: dout_vld=%0b required 0", d2_vld);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_stall_bubbles();
    logic [0:11]        ce_pat = 12'b110001111111;
    logic [0:11]        v_pat  = 12'b101111100000;
    exp_t               e;
    bit                 prev_ce  = 1'b1;
    logic               last_vld = 1'b0;
    logic               last_ovf = 1'b0;
    logic signed [30:0] last_dout = '0;
    int                 n_out = 0;
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (!prev_ce) begin
        if (d0_vld !== last_vld || (last_vld && (d0_dout !== last_dout || d0_ovf !== last_ovf))) begin
          n_fail++; $display("FAIL stall_hold: got vld=%0b dout=%0d ovf=%0b required vld=%0b dout=%0d ovf=%0b",
                             d0_vld, d0_dout, d0_ovf, last_vld, last_dout, last_ovf);
        end
      end else if (d0_vld) begin
        n_out++;
        if (q0.size() == 0) begin
          n_fail++; $display("FAIL stall_extra: dout_vld=1 required 0 at edge %0d", en_cnt);
        end else begin
          e = q0.pop_front();
          if (e.due != en_cnt || longint'(d0_dout) !== e.val || d0_ovf !== e.ovf) begin
            n_fail++; $display("FAIL stall_out: got dout=%0d ovf=%0b edge %0d required dout=%0d ovf=%0b edge %0d",
                               d0_dout, d0_ovf, en_cnt, e.val, e.ovf, e.due);
          end
        end
      end else if (q0.size() != 0 && q0[0].due <= en_cnt) begin
        n_fail++; $display("FAIL stall_missing: dout_vld=0 required 1 at edge %0d", q0[0].due);
      end
      last_vld  = d0_vld;
      last_dout = d0_dout;
      last_ovf  = d0_ovf;
      drive(ce_pat[i], v_pat[i], -1234 * (i + 1), 777 * (i + 3), i[0]);
      prev_ce = ce_pat[i];
      tick();
    end
    n_chk++;
    if (n_out != 3 || q0.size() != 0) begin
      n_fail++; $display("FAIL stall_count: got %0d outputs %0d pending required 3 outputs 0 pending", n_out, q0.size());
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b1, -65536, 32767, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1000, -999, 1'b1);
    tick();
    n_chk++;
    if (d0_vld !== 1'b1 || d0_ovf !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: got vld=%0b ovf=%0b required vld=1 ovf=1", d0_vld, d0_ovf);
    end
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    tick();
    n_chk += 2;
    if (d0_vld !== 1'b0 || d0_dout !== 31'sd0 || d0_ovf !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_d0: got vld=%0b dout=%0d ovf=%0b required 0/0/0", d0_vld, d0_dout, d0_ovf);
    end
    if (d1_vld !== 1'b0 || d1_dout !== 36'sd0 || d1_ovf !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_d1: got vld=%0b dout=%0d ovf=%0b required 0/0/0", d1_vld, d1_dout, d1_ovf);
    end
    rst_n = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 0, 0, 1'b0);
      tick();
      n_chk++;
      if (d0_vld !== 1'b0 || d1_vld !== 1'b0 || d2_vld !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_stale[%0d]: got vld=%0b%0b%0b required 000", i, d0_vld, d1_vld, d2_vld);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_corner_negate();
    test_shift_floor();
    test_stall_bubbles();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tc_mul_pipe.md
# tc_mul_pipe

Parametrised, pipelined signed multiplier for the TrackletCalculator datapath. It is the successor to the fixed-width single-cycle `mul_17s_18s_31` cores. Widths, pipeline depth and a fixed-point right shift are configurable. It adds a valid pipeline, a clock-enable stall, a per-transaction negate control, and an optional saturating output. It sits between the TC operand registers and the tracklet-parameter adders, replacing the per-width HLS multiplier instances.

## Interface
- `DIN0_WIDTH`, default 17: signed width of `din0`, range 2..27.
- `DIN1_WIDTH`, default 18: signed width of `din1`, range 2..27.
- `DOUT_WIDTH`, default 31: signed width of `dout`, range 2..(DIN0_WIDTH+DIN1_WIDTH+1).
- `NUM_STAGE`, default 2: register stages from input to output, range 1..4.
- `SHIFT`, default 0: arithmetic right shift applied to the product before narrowing, range 0..(DIN0_WIDTH+DIN1_WIDTH-1).
- `ap_clk`, in, 1: clock; all state is updated on the rising edge.
- `ap_rst_n`, in, 1: synchronous, active-low reset.
- `ce`, in, 1: clock enable; when low, every pipeline register holds.
- `din_vld`, in, 1: operands valid this cycle.
- `din0`, in, DIN0_WIDTH: signed operand A.
- `din1`, in, DIN1_WIDTH: signed operand B.
- `neg`, in, 1: when 1, the result is −(A·B).
- `dout_vld`, out, 1: `dout` holds a result.
- `dout`, out, DOUT_WIDTH: signed result.
- `ovf`, out, 1: the result was out of the DOUT range (wrapped or saturated); qualified by `dout_vld`.

## Operation
- Full product: P = A·B, computed exactly in PW = DIN0_WIDTH+DIN1_WIDTH bits.
- Negate: Q = neg ? −P : P, computed in PW+1 bits.
  - Required so that −(−2^(A−1)·−2^(B−1)) is exact.
- Shift: R = Q >>> SHIFT (arithmetic shift, floor rounding toward −∞). No rounding increment.
- Narrow to DOUT_WIDTH:
  - Default: keep the low DOUT_WIDTH bits (two's-complement wrap, matching the legacy HLS cores). `ovf` = 1 when R ∉ [−2^(DOUT−1), 2^(DOUT−1)−1].
  - With saturation compiled in: see Configuration.
- Valid pipeline: `din_vld` travels alongside the data through NUM_STAGE registers.
  - Data registers load on every `ce`-high cycle regardless of valid. The product register may be unloaded when valid is 0.
  - `dout` is don't-care when `dout_vld` = 0; the bench must not check it.
- Stage split:
  - Stage 1 registers the operands and `neg`.
  - The multiply and negate complete by stage NUM_STAGE−1 (if NUM_STAGE ≥ 2).
  - Shift, narrow and `ovf` are registered in the final stage.
  - For NUM_STAGE = 1, all arithmetic is combinational between the input registers and `dout`. The input registers are then the output registers; the whole path is one register stage.
- No backpressure. The consumer must accept `dout` in the cycle `dout_vld` is high with `ce` high.

## Timing
- Latency: a sample presented with `din_vld` = 1 on a `ce`-high edge appears on `dout`/`dout_vld` exactly NUM_STAGE `ce`-high edges later.
- Throughput: one sample per cycle. Back-to-back valids give back-to-back outputs in order.
- `ce` = 0: all registers, including the valid chain, hold. Outputs stay frozen and may remain valid across the stall. The result emerges after NUM_STAGE enabled edges.
- Reset: on an edge with `ap_rst_n` = 0, all valid bits, `dout` and `ovf` clear to 0, independent of `ce`.
  - In-flight samples are discarded.
  - The first valid output after reset release requires a new input plus NUM_STAGE edges.
- `din_vld` = 0 inserts a bubble: `dout_vld` = 0 in the corresponding output cycle.

## Configuration
- `TC_MUL_SAT_EN` defined: the narrow step clamps R.
  - R > 2^(DOUT−1)−1 → 2^(DOUT−1)−1.
  - R < −2^(DOUT−1) → −2^(DOUT−1).
  - `ovf` = 1 when clamping occurred.
- `TC_MUL_SAT_EN` undefined: wrap behaviour as above. `ovf` still reports out-of-range results.
- When DOUT_WIDTH ≥ PW+1−SHIFT, overflow cannot occur: `ovf` is constant 0 in both builds.

## Test plan
- Defaults, NUM_STAGE=2: din0=−3, din1=5, neg=0, one valid → `dout`=−15, `ovf`=0, `dout_vld` high exactly 2 cycles after input, for 1 cycle.
- Corner negate (17,18,DOUT=36,SHIFT=0): din0=−65536, din1=−131072, neg=1 → `dout`=−2^33, `ovf`=0.
- Overflow (defaults, din0=−65536, din1=−131072, neg=0, P=2^33):
  - Wrap build → `dout`=0 (low 31 bits), `ovf`=1.
  - TC_MUL_SAT_EN build → `dout`=2^30−1, `ovf`=1.
- Shift floor: SHIFT=4, din0=−1, din1=7 → `dout`=−1; din0=1, din1=15 → `dout`=0.
- Stall and bubbles: stream valids 1,0,1,1 with `ce` low for 3 cycles mid-stream → outputs in order with one bubble, each delayed by exactly 3 cycles, outputs held unchanged during the stall.
- Reset mid-stream: assert `ap_rst_n`=0 for 1 cycle with 2 samples in flight and `ce`=0 → next edge `dout_vld`=0, `dout`=0, `ovf`=0; no stale output emerges afterwards.
